// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
// NOP_INST is the word the output stage holds whenever it has nothing valid to present.
package fetch_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_INST_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0007_8000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM and
// registers each fetched word into a valid/ready stage toward decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter int               INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit               WRAP     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  output logic [15:0]       fetch_cnt
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_HALT = HALT;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              load;
  logic              at_last;

  assign accept  = if_valid & if_ready;
  assign load    = (state == ST_RUN) & (!if_valid | if_ready) & !redirect;
  assign at_last = (pc == {ADDR_W{1'b1}});

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  // Redirect outranks everything, including a halt request in the same cycle;
  // a load from the last address halts instead of wrapping when WRAP is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      if_valid  <= 1'b0;
      if_inst   <= INST_W'(NOP_INST);
      if_pc     <= '0;
      fetch_cnt <= 16'd0;
    end else begin
      if (accept) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end

      if (redirect) begin
        pc       <= redirect_pc;
        if_valid <= 1'b0;
        if_inst  <= INST_W'(NOP_INST);
        state    <= ST_RUN;
      end else begin
        if (load) begin
          if_inst  <= imem_inst;
          if_pc    <= pc;
          if_valid <= 1'b1;
          if (!WRAP && at_last) begin
            state <= ST_HALT;
          end else begin
            pc <= pc + 1'b1;
          end
        end else if (accept) begin
          if_valid <= 1'b0;
          if_inst  <= INST_W'(NOP_INST);
        end

        if ((state == ST_RUN) && halt_req) begin
          state <= ST_HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one wrapping instance and one auto-halting
// instance share stimulus, each fed by its own copy of a behavioural ROM.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        halt_req;

  logic [5:0]  imem_addr,  nw_imem_addr;
  logic [31:0] imem_inst,  nw_imem_inst;
  logic        if_valid,   nw_if_valid;
  logic [31:0] if_inst,    nw_if_inst;
  logic [5:0]  if_pc,      nw_if_pc;
  logic        halted,     nw_halted;
  logic [15:0] fetch_cnt,  nw_fetch_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    if (a == 6'd1) return 32'h8008_0001;
    if (a == 6'd2) return 32'h8210_0001;
    return 32'hC000_0000 | 32'(a);
  endfunction

  assign imem_inst    = rom_word(imem_addr);
  assign nw_imem_inst = rom_word(nw_imem_addr);

  fetch_ctrl #(.ADDR_W(6), .INST_W(32), .RESET_PC(6'd0), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  fetch_ctrl #(.ADDR_W(6), .INST_W(32), .RESET_PC(6'd0), .WRAP(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .imem_addr(nw_imem_addr), .imem_inst(nw_imem_inst),
    .if_valid(nw_if_valid), .if_ready(if_ready), .if_inst(nw_if_inst), .if_pc(nw_if_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(nw_halted), .fetch_cnt(nw_fetch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 6'd0; halt_req = 1'b0;
    tick();
    tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (if_inst !== NOP_INST) begin bad++; $display("[TB] FAIL reset_inst got=%h exp=%h", if_inst, NOP_INST); end
    total++; if (imem_addr !== 6'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d exp=0", imem_addr); end
    total++; if (if_pc !== 6'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d exp=0", if_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    total++; if (fetch_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
  endtask

  task automatic test_stream();
    rst = 1'b0; if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (if_valid !== 1'b1 || if_pc !== 6'(k)) begin bad++; $display("[TB] FAIL stream_pc%0d got=%0d/%b exp=%0d/1", k, if_pc, if_valid, k); end
      total++; if (fetch_cnt !== 16'(k)) begin bad++; $display("[TB] FAIL stream_cnt%0d got=%0d exp=%0d", k, fetch_cnt, k); end
      if (k == 1) begin
        total++; if (if_inst !== 32'h8008_0001) begin bad++; $display("[TB] FAIL stream_inst1 got=%h exp=80080001", if_inst); end
      end
      if (k == 2) begin
        total++; if (if_inst !== 32'h8210_0001) begin bad++; $display("[TB] FAIL stream_inst2 got=%h exp=82100001", if_inst); end
      end
    end
  endtask

  task automatic test_stall();
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (if_pc !== 6'd3 || if_inst !== 32'hC000_0003 || imem_addr !== 6'd4 || if_valid !== 1'b1)
        begin bad++; $display("[TB] FAIL stall_hold%0d got pc=%0d inst=%h addr=%0d exp pc=3 inst=c0000003 addr=4", k, if_pc, if_inst, imem_addr); end
      total++; if (fetch_cnt !== 16'd3) begin bad++; $display("[TB] FAIL stall_cnt%0d got=%0d exp=3", k, fetch_cnt); end
    end
    if_ready = 1'b1;
    tick();
    total++; if (if_pc !== 6'd4 || fetch_cnt !== 16'd4) begin bad++; $display("[TB] FAIL release_pc4 got pc=%0d cnt=%0d exp pc=4 cnt=4", if_pc, fetch_cnt); end
    tick();
    total++; if (if_pc !== 6'd5 || fetch_cnt !== 16'd5 || imem_addr !== 6'd6) begin bad++; $display("[TB] FAIL release_pc5 got pc=%0d cnt=%0d addr=%0d exp 5/5/6", if_pc, fetch_cnt, imem_addr); end
  endtask

  task automatic test_redirect();
    if_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 6'd8;
    tick();
    total++; if (if_valid !== 1'b0 || imem_addr !== 6'd8) begin bad++; $display("[TB] FAIL redir_squash got valid=%b addr=%0d exp 0/8", if_valid, imem_addr); end
    total++; if (if_inst !== NOP_INST) begin bad++; $display("[TB] FAIL redir_nop got=%h exp=%h", if_inst, NOP_INST); end
    redirect = 1'b0; if_ready = 1'b1;
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 6'd8 || if_inst !== 32'hC000_0008) begin bad++; $display("[TB] FAIL redir_target got pc=%0d inst=%h exp 8/c0000008", if_pc, if_inst); end
    total++; if (fetch_cnt !== 16'd5) begin bad++; $display("[TB] FAIL redir_cnt got=%0d exp=5", fetch_cnt); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 6'd5;
    tick();
    redirect = 1'b0;
    tick();
    total++; if (if_pc !== 6'd5 || fetch_cnt !== 16'd6) begin bad++; $display("[TB] FAIL halt_setup got pc=%0d cnt=%0d exp 5/6", if_pc, fetch_cnt); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total++; if (halted !== 1'b1 || if_valid !== 1'b1 || if_pc !== 6'd6) begin bad++; $display("[TB] FAIL halt_enter got halted=%b valid=%b pc=%0d exp 1/1/6", halted, if_valid, if_pc); end
    tick();
    total++; if (if_valid !== 1'b0 || fetch_cnt !== 16'd8 || imem_addr !== 6'd7) begin bad++; $display("[TB] FAIL halt_drain got valid=%b cnt=%0d addr=%0d exp 0/8/7", if_valid, fetch_cnt, imem_addr); end
    tick();
    total++; if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 6'd7) begin bad++; $display("[TB] FAIL halt_frozen got valid=%b halted=%b addr=%0d exp 0/1/7", if_valid, halted, imem_addr); end
    redirect = 1'b1; redirect_pc = 6'd0;
    tick();
    redirect = 1'b0;
    total++; if (halted !== 1'b0 || imem_addr !== 6'd0) begin bad++; $display("[TB] FAIL halt_exit got halted=%b addr=%0d exp 0/0", halted, imem_addr); end
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 6'd0 || if_inst !== 32'hC000_0000) begin bad++; $display("[TB] FAIL halt_resume got valid=%b pc=%0d inst=%h exp 1/0/c0000000", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_reset_mid();
    if_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++; if (if_valid !== 1'b0 || if_inst !== NOP_INST || if_pc !== 6'd0 || imem_addr !== 6'd0 || fetch_cnt !== 16'd0 || halted !== 1'b0)
      begin bad++; $display("[TB] FAIL rst_stall got valid=%b inst=%h pc=%0d addr=%0d cnt=%0d halted=%b", if_valid, if_inst, if_pc, imem_addr, fetch_cnt, halted); end
    rst = 1'b0; if_ready = 1'b1; halt_req = 1'b1;
    tick();
    halt_req = 1'b0; if_ready = 1'b0;
    tick();
    total++; if (halted !== 1'b1 || if_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_prehalt got halted=%b valid=%b exp 1/1", halted, if_valid); end
    rst = 1'b1;
    tick();
    total++; if (if_valid !== 1'b0 || if_inst !== NOP_INST || if_pc !== 6'd0 || imem_addr !== 6'd0 || fetch_cnt !== 16'd0 || halted !== 1'b0)
      begin bad++; $display("[TB] FAIL rst_halt got valid=%b inst=%h pc=%0d addr=%0d cnt=%0d halted=%b", if_valid, if_inst, if_pc, imem_addr, fetch_cnt, halted); end
  endtask

  task automatic test_redirect_and_halt();
    rst = 1'b0; if_ready = 1'b1; redirect = 1'b1; redirect_pc = 6'd20; halt_req = 1'b1;
    tick();
    redirect = 1'b0; halt_req = 1'b0;
    total++; if (halted !== 1'b0 || imem_addr !== 6'd20 || if_valid !== 1'b0) begin bad++; $display("[TB] FAIL both_redir got halted=%b addr=%0d valid=%b exp 0/20/0", halted, imem_addr, if_valid); end
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 6'd20 || halted !== 1'b0) begin bad++; $display("[TB] FAIL both_run got valid=%b pc=%0d halted=%b exp 1/20/0", if_valid, if_pc, halted); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; halt_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (64) tick();
    total++; if (if_pc !== 6'd63 || nw_if_pc !== 6'd63 || nw_if_inst !== 32'hC000_003F) begin bad++; $display("[TB] FAIL end_pc63 got pc=%0d nw_pc=%0d nw_inst=%h exp 63/63/c000003f", if_pc, nw_if_pc, nw_if_inst); end
    total++; if (nw_halted !== 1'b1 || nw_imem_addr !== 6'd63 || halted !== 1'b0) begin bad++; $display("[TB] FAIL end_halt got nw_halted=%b nw_addr=%0d halted=%b exp 1/63/0", nw_halted, nw_imem_addr, halted); end
    tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 6'd0) begin bad++; $display("[TB] FAIL wrap_pc0 got valid=%b pc=%0d exp 1/0", if_valid, if_pc); end
    total++; if (nw_if_valid !== 1'b0 || nw_halted !== 1'b1 || nw_imem_addr !== 6'd63) begin bad++; $display("[TB] FAIL nowrap_stop got valid=%b halted=%b addr=%0d exp 0/1/63", nw_if_valid, nw_halted, nw_imem_addr); end
    total++; if (fetch_cnt !== 16'd64 || nw_fetch_cnt !== 16'd64) begin bad++; $display("[TB] FAIL end_cnt got cnt=%0d nw_cnt=%0d exp 64/64", fetch_cnt, nw_fetch_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_redirect_and_halt();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
